// File: rtl/board_b_rom_responder.sv
// Tile ROM responder: turns a layer longword fetch into two 16-bit SDRAM reads.
// Define ROM_CACHE_EN to add a one-entry longword cache in front of SDRAM.
module board_b_rom_responder #(
  parameter logic [24:0] BASE_ADDR = 25'h0000000
) (
  input  logic        CLK_32M,
  input  logic        reset,
  input  logic        sdr_req,
  input  logic [20:0] sdr_addr,
  output logic [31:0] sdr_data,
  output logic        sdr_rdy,
  output logic [24:0] ram_addr,
  output logic        ram_req,
  input  logic        ram_ack,
  input  logic [15:0] ram_dout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT0 = 2'd1,
    BEAT1 = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [20:0] cur_addr_q, cur_addr_d;
  logic [20:0] pend_addr_q, pend_addr_d;
  logic        pend_valid_q, pend_valid_d;
  logic [24:0] ram_addr_q, ram_addr_d;
  logic        ram_req_q, ram_req_d;
  logic [31:0] sdr_data_q, sdr_data_d;
  logic        sdr_rdy_q, sdr_rdy_d;

  logic        start_s;
  logic [20:0] start_addr_s;
  logic        hit_s;
  logic        cache_hit_s;
  logic [31:0] cache_data_s;
  logic        unused_s;

`ifdef ROM_CACHE_EN
  logic [18:0] cache_tag_q, cache_tag_d;
  logic [31:0] cache_data_q, cache_data_d;
  logic        cache_valid_q, cache_valid_d;

  // The entry is refreshed with every completed fetch, during its DONE cycle.
  assign cache_tag_d   = (state_q == DONE) ? cur_addr_q[20:2] : cache_tag_q;
  assign cache_data_d  = (state_q == DONE) ? sdr_data_q : cache_data_q;
  assign cache_valid_d = (state_q == DONE) ? 1'b1 : cache_valid_q;
  assign cache_hit_s   = cache_valid_q && (cache_tag_q == sdr_addr[20:2]);
  assign cache_data_s  = cache_data_q;

  always_ff @(posedge CLK_32M or posedge reset) begin
    if (reset) begin
      cache_tag_q   <= 19'd0;
      cache_data_q  <= 32'd0;
      cache_valid_q <= 1'b0;
    end else begin
      cache_tag_q   <= cache_tag_d;
      cache_data_q  <= cache_data_d;
      cache_valid_q <= cache_valid_d;
    end
  end
`else
  assign cache_hit_s  = 1'b0;
  assign cache_data_s = 32'd0;
`endif

  assign unused_s = ^{cur_addr_q[1:0], pend_addr_q[1:0], sdr_addr[1:0]};

  always_ff @(posedge CLK_32M or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cur_addr_q   <= 21'd0;
      pend_addr_q  <= 21'd0;
      pend_valid_q <= 1'b0;
      ram_addr_q   <= 25'd0;
      ram_req_q    <= 1'b0;
      sdr_data_q   <= 32'd0;
      sdr_rdy_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_addr_q   <= cur_addr_d;
      pend_addr_q  <= pend_addr_d;
      pend_valid_q <= pend_valid_d;
      ram_addr_q   <= ram_addr_d;
      ram_req_q    <= ram_req_d;
      sdr_data_q   <= sdr_data_d;
      sdr_rdy_q    <= sdr_rdy_d;
    end
  end

  // A request arriving in DONE is newer than the pending one, so it wins.
  always_comb begin
    state_d      = state_q;
    start_s      = 1'b0;
    start_addr_s = sdr_addr;
    hit_s        = 1'b0;
    case (state_q)
      IDLE: begin
        if (sdr_req && cache_hit_s) begin
          hit_s = 1'b1;
        end else if (sdr_req) begin
          start_s = 1'b1;
          state_d = BEAT0;
        end else begin
          state_d = IDLE;
        end
      end
      BEAT0: begin
        if (ram_ack) begin
          state_d = BEAT1;
        end else begin
          state_d = BEAT0;
        end
      end
      BEAT1: begin
        if (ram_ack) begin
          state_d = DONE;
        end else begin
          state_d = BEAT1;
        end
      end
      DONE: begin
        if (sdr_req) begin
          start_s = 1'b1;
          state_d = BEAT0;
        end else if (pend_valid_q) begin
          start_s      = 1'b1;
          start_addr_s = pend_addr_q;
          state_d      = BEAT0;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cur_addr_d   = cur_addr_q;
    pend_addr_d  = pend_addr_q;
    pend_valid_d = pend_valid_q;
    ram_addr_d   = ram_addr_q;
    ram_req_d    = ram_req_q;
    sdr_data_d   = sdr_data_q;
    sdr_rdy_d    = 1'b0;
    if (start_s) begin
      cur_addr_d   = start_addr_s;
      ram_addr_d   = BASE_ADDR + {5'b00000, start_addr_s[20:2], 1'b0};
      ram_req_d    = 1'b1;
      pend_valid_d = 1'b0;
    end else begin
      pend_valid_d = pend_valid_q;
    end
    if (sdr_req && ((state_q == BEAT0) || (state_q == BEAT1))) begin
      pend_addr_d  = sdr_addr;
      pend_valid_d = 1'b1;
    end else begin
      pend_addr_d = pend_addr_q;
    end
    case (state_q)
      IDLE: begin
        if (hit_s) begin
          sdr_rdy_d  = 1'b1;
          sdr_data_d = cache_data_s;
        end else begin
          sdr_rdy_d = 1'b0;
        end
      end
      BEAT0: begin
        if (ram_ack) begin
          sdr_data_d[15:0] = ram_dout;
          ram_addr_d       = BASE_ADDR + {5'b00000, cur_addr_q[20:2], 1'b1};
        end else begin
          ram_addr_d = ram_addr_q;
        end
      end
      BEAT1: begin
        if (ram_ack) begin
          sdr_data_d[31:16] = ram_dout;
          ram_req_d         = 1'b0;
          sdr_rdy_d         = 1'b1;
        end else begin
          ram_req_d = ram_req_q;
        end
      end
      default: sdr_rdy_d = 1'b0;
    endcase
  end

  assign sdr_data = sdr_data_q;
  assign sdr_rdy  = sdr_rdy_q;
  assign ram_addr = ram_addr_q;
  assign ram_req  = ram_req_q;

endmodule

// File: tb/tb_board_b_rom_responder.sv
// Bench for board_b_rom_responder: directed scenarios plus a random run, all
// checked cycle by cycle against a transaction-level model of a fetch.
module tb_board_b_rom_responder;

  localparam logic [24:0] B1 = 25'h0000000;
  localparam logic [24:0] B2 = 25'h1FFFFFF;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        sdr_req = 1'b0;
  logic [20:0] sdr_addr = 21'd0;
  logic        ram_ack = 1'b0;
  logic [15:0] ram_dout = 16'd0;
  logic [31:0] sdr_data, w_sdr_data;
  logic        sdr_rdy, w_sdr_rdy;
  logic [24:0] ram_addr, w_ram_addr;
  logic        ram_req, w_ram_req;

  board_b_rom_responder #(.BASE_ADDR(B1)) dut (
    .CLK_32M(clk), .reset(reset), .sdr_req(sdr_req), .sdr_addr(sdr_addr),
    .sdr_data(sdr_data), .sdr_rdy(sdr_rdy), .ram_addr(ram_addr),
    .ram_req(ram_req), .ram_ack(ram_ack), .ram_dout(ram_dout)
  );

  board_b_rom_responder #(.BASE_ADDR(B2)) dut_wrap (
    .CLK_32M(clk), .reset(reset), .sdr_req(sdr_req), .sdr_addr(sdr_addr),
    .sdr_data(w_sdr_data), .sdr_rdy(w_sdr_rdy), .ram_addr(w_ram_addr),
    .ram_req(w_ram_req), .ram_ack(ram_ack), .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int rdy_seen = 0;

  // Model: fetch phase (0 idle, 1 reading, 2 result cycle), words read so far.
  int          m_phase;
  int          m_beats;
  logic [18:0] m_word;
  bit          m_pend_v;
  logic [18:0] m_pend_word;
  logic [31:0] m_data;
  bit          m_hit_rdy;
  bit          m_cv;
  logic [18:0] m_cword;
  logic [31:0] m_cdata;

  bit          use_fix = 1'b0;
  logic [15:0] fix_lo = 16'h1122;
  logic [15:0] fix_hi = 16'h3344;

  function automatic logic [15:0] dout_of(input logic [24:0] a);
    if (use_fix) return a[0] ? fix_hi : fix_lo;
    return a[15:0] ^ {a[24:16], a[6:0]} ^ 16'h5A3C;
  endfunction

  function automatic logic [24:0] exp_addr(input logic [24:0] base);
    return base + {5'b00000, m_word, 1'b0} + 25'(m_beats);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_beats = 0; m_word = 19'd0; m_pend_v = 1'b0;
    m_pend_word = 19'd0; m_data = 32'd0; m_hit_rdy = 1'b0; m_cv = 1'b0;
    m_cword = 19'd0; m_cdata = 32'd0;
  endtask

  task automatic model_start(input logic [18:0] w);
    m_phase = 1; m_beats = 0; m_word = w; m_pend_v = 1'b0;
  endtask

  task automatic model_edge(input bit req, input logic [20:0] addr, input bit ack);
    m_hit_rdy = 1'b0;
    case (m_phase)
      0: if (req) begin
`ifdef ROM_CACHE_EN
        if (m_cv && (m_cword == addr[20:2])) begin
          m_hit_rdy = 1'b1;
          m_data    = m_cdata;
        end else
`endif
        model_start(addr[20:2]);
      end
      1: begin
        if (req) begin
          m_pend_v    = 1'b1;
          m_pend_word = addr[20:2];
        end
        if (ack && (m_beats == 0)) begin
          m_data[15:0] = dout_of(exp_addr(B1));
          m_beats = 1;
        end else if (ack) begin
          m_data[31:16] = dout_of(exp_addr(B1));
          m_phase = 2;
        end
      end
      default: begin
        m_cv = 1'b1; m_cword = m_word; m_cdata = m_data;
        if (req) model_start(addr[20:2]);
        else if (m_pend_v) model_start(m_pend_word);
        else m_phase = 0;
      end
    endcase
  endtask

  task automatic tick(input bit req, input logic [20:0] addr, input bit ack_ok, input bit force_ack);
    bit ack;
    sdr_req  = req;
    sdr_addr = addr;
    ack      = force_ack || (ack_ok && ram_req);
    ram_ack  = ack;
    ram_dout = dout_of(ram_addr);
    @(posedge clk);
    model_edge(req, addr, ack);
    #1;
    if (sdr_rdy) rdy_seen++;
    chk("sdr_rdy", 32'(sdr_rdy), 32'(m_phase == 2 || m_hit_rdy));
    chk("ram_req", 32'(ram_req), 32'(m_phase == 1));
    chk("sdr_data", sdr_data, m_data);
    if (m_phase == 1) begin
      chk("ram_addr", 32'(ram_addr), 32'(exp_addr(B1)));
      chk("ram_addr_wrap", 32'(w_ram_addr), 32'(exp_addr(B2)));
    end
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 21'd0, 1'b1, 1'b0);
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    sdr_req  = 1'b0;
    ram_ack  = 1'b0;
    #1;
    model_reset();
    chk("rst_ram_req", 32'(ram_req), 32'd0);
    chk("rst_sdr_rdy", 32'(sdr_rdy), 32'd0);
    chk("rst_ram_addr", 32'(ram_addr), 32'd0);
    chk("rst_sdr_data", sdr_data, 32'd0);
    chk("rst_wrap_addr", 32'(w_ram_addr), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    int base_rdy;
    bit rq;
    logic [20:0] a;
    #2;
    do_reset();

    // Single fetch with the fixed data words, earliest acks.
    use_fix = 1'b1;
    rdy_seen = 0;
    tick(1'b1, 21'h000104, 1'b1, 1'b0);
    chk("t030_addr0", 32'(ram_addr), 32'h82);
    tick(1'b0, 21'd0, 1'b1, 1'b0);
    chk("t030_addr1", 32'(ram_addr), 32'h83);
    tick(1'b0, 21'd0, 1'b1, 1'b0);
    chk("t030_rdy", 32'(sdr_rdy), 32'd1);
    chk("t030_data", sdr_data, 32'h33441122);
    drain(3);
    chk("t030_pulses", rdy_seen, 32'd1);

    // Repeat of the same longword.
    tick(1'b1, 21'h000104, 1'b1, 1'b0);
`ifdef ROM_CACHE_EN
    chk("t034_rdy", 32'(sdr_rdy), 32'd1);
    chk("t034_req", 32'(ram_req), 32'd0);
    chk("t034_data", sdr_data, 32'h33441122);
`endif
    drain(5);

    // Newest pending request replaces older ones.
    use_fix = 1'b0;
    rdy_seen = 0;
    tick(1'b1, 21'h000010, 1'b0, 1'b0);
    tick(1'b1, 21'h000020, 1'b0, 1'b0);
    tick(1'b1, 21'h000030, 1'b0, 1'b0);
    drain(10);
    chk("t031_pulses", rdy_seen, 32'd2);

    // Long stall in the first beat.
    rdy_seen = 0;
    tick(1'b1, 21'h000200, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) tick(1'b0, 21'd0, 1'b0, 1'b0);
    chk("t032_addr", 32'(ram_addr), 32'h100);
    chk("t032_nordy", rdy_seen, 32'd0);
    drain(4);
    chk("t032_pulses", rdy_seen, 32'd1);

    // Reset in the second beat with a request pending, then stray acks.
    tick(1'b1, 21'h000044, 1'b1, 1'b0);
    tick(1'b0, 21'd0, 1'b1, 1'b0);
    tick(1'b1, 21'h000048, 1'b0, 1'b0);
    do_reset();
    rdy_seen = 0;
    for (int i = 0; i < 3; i++) tick(1'b0, 21'd0, 1'b0, 1'b1);
    chk("t033_stray", rdy_seen, 32'd0);
    use_fix = 1'b1;
    tick(1'b1, 21'h000104, 1'b1, 1'b0);
    chk("t033_req", 32'(ram_req), 32'd1);
    chk("t033_addr0", 32'(ram_addr), 32'h82);
    drain(2);
    chk("t033_data", sdr_data, 32'h33441122);
    drain(2);

    // Base + address wraps modulo 2^25.
    use_fix = 1'b0;
    tick(1'b1, 21'h000000, 1'b1, 1'b0);
    chk("t035_addr0", 32'(w_ram_addr), 32'h1FFFFFF);
    tick(1'b0, 21'd0, 1'b1, 1'b0);
    chk("t035_addr1", 32'(w_ram_addr), 32'h0000000);
    drain(3);

    // Random traffic with random ack timing and a mid-run reset.
    base_rdy = rdy_seen;
    for (int i = 0; i < 600; i++) begin
      if (i == 300) do_reset();
      rq = ($urandom_range(0, 3) == 0);
      a  = ($urandom_range(0, 1) == 1) ? 21'($urandom_range(0, 7) * 4)
                                       : (21'($urandom) & 21'h1FFFFC);
      tick(rq, a, ($urandom_range(0, 1) == 1), ($urandom_range(0, 15) == 0));
    end
    drain(20);
    chk("rand_activity", 32'(rdy_seen > base_rdy), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/board_b_rom_responder.md
BOARD_B_ROM_RESPONDER -- requirements
Module: board_b_rom_responder

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 25'h0000000, meaning the 16-bit-word base address of the tile ROM region in SDRAM.
REQ-002 SHALL have port CLK_32M, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port sdr_req, input, 1 bit: a one-cycle layer fetch strobe.
REQ-005 SHALL have port sdr_addr, input, 21 bits: the layer byte address; bits [1:0] are always 00.
REQ-006 SHALL have port sdr_data, output, 32 bits: the returned tile ROM longword.
REQ-007 SHALL have port sdr_rdy, output, 1 bit: a one-cycle strobe marking sdr_data valid.
REQ-008 SHALL have port ram_addr, output, 25 bits: the SDRAM 16-bit word address.
REQ-009 SHALL have port ram_req, output, 1 bit: a level request, held until acknowledged.
REQ-010 SHALL have port ram_ack, input, 1 bit: a one-cycle pulse marking ram_dout valid.
REQ-011 SHALL have port ram_dout, input, 16 bits: the SDRAM read word.

Function
REQ-012 SHALL implement the states IDLE, BEAT0, BEAT1 and DONE.
REQ-013 In IDLE, sdr_req SHALL do all of the following on the same edge:
- latch sdr_addr into cur_addr;
- drive ram_addr = BASE_ADDR + {sdr_addr[20:2], 1'b0};
- assert ram_req;
- enter BEAT0.
REQ-014 In BEAT0, ram_ack SHALL latch ram_dout into sdr_data[15:0], set ram_addr to the base+1 word, keep ram_req high and enter BEAT1.
REQ-015 In BEAT1, ram_ack SHALL latch ram_dout into sdr_data[31:16], deassert ram_req and enter DONE.
REQ-016 DONE SHALL assert sdr_rdy for exactly one cycle.
- If a request is pending, DONE SHALL start it as in REQ-013.
- Otherwise DONE SHALL return to IDLE.
REQ-017 ram_req SHALL never drop between the two beats of one fetch.
REQ-018 ram_addr SHALL be stable whenever ram_req is high and no ram_ack is occurring.
REQ-019 sdr_req while busy (BEAT0, BEAT1 or DONE) SHALL store sdr_addr in a one-deep pending register and set pend_valid.
- A later sdr_req SHALL overwrite the pending address, so the newest request wins.
- The in-flight fetch SHALL never be aborted.
REQ-020 sdr_req coinciding with DONE SHALL be treated as pending and started on that DONE edge; no request is lost.
REQ-021 ram_ack in IDLE or DONE SHALL be ignored.
REQ-022 sdr_data SHALL hold its value between sdr_rdy pulses.
- Only the low half changes at the BEAT0 ack.
- Only the high half changes at the BEAT1 ack.
REQ-023 Latency with ram_ack granted at the earliest opportunity SHALL be:
- sdr_req at cycle N;
- ram_req high from N+1;
- acks at N+1 and N+2;
- sdr_rdy at N+3.
REQ-024 The address sum SHALL wrap modulo 2^25.

Reset
REQ-025 Reset SHALL force all of the following asynchronously:
- state = IDLE;
- ram_req = 0, ram_addr = 0;
- sdr_rdy = 0, sdr_data = 0;
- pend_valid = 0, cur_addr = 0.
REQ-026 Reset mid-fetch SHALL discard the fetch and any pending request with no sdr_rdy. Any ram_ack arriving after reset release while in IDLE is ignored.

Configuration
REQ-027 Macro ROM_CACHE_EN SHALL compile in a one-entry longword cache (tag = sdr_addr[20:2], data, valid).
- The cache is filled at every DONE.
- The cache is invalidated by reset only.
REQ-028 With ROM_CACHE_EN defined, an IDLE sdr_req whose tag matches a valid entry SHALL:
- assert sdr_rdy with the cached data on the next cycle;
- leave ram_req low;
- stay in IDLE.
REQ-029 With ROM_CACHE_EN undefined, every request SHALL access SDRAM. No tag or valid registers SHALL exist.

Verification
REQ-030 Single fetch: BASE_ADDR=0, sdr_addr=21'h000104, acks returning 16'h1122 then 16'h3344.
- ram_addr SHALL be 0x82 then 0x83.
- sdr_data SHALL be 32'h33441122 with a single sdr_rdy pulse.
REQ-031 Overwrite: sdr_req 0x10 accepted, then 0x20 and 0x30 sent during BEAT0. Fetches SHALL occur for 0x10 then 0x30 only, giving two sdr_rdy pulses.
REQ-032 Stalled ack: ram_ack withheld 20 cycles in BEAT0. ram_req and ram_addr SHALL stay stable, and sdr_rdy SHALL remain 0 until the second ack +1.
REQ-033 Reset while in BEAT1:
- ram_req SHALL be 0 immediately;
- a later stray ram_ack SHALL produce no sdr_rdy;
- the next request SHALL behave as in REQ-030.
REQ-034 With ROM_CACHE_EN, a repeat request for 0x104 after REQ-030 SHALL give sdr_rdy one cycle later, data 32'h33441122, and no ram_req.
REQ-035 With BASE_ADDR=25'h1FFFFFF, sdr_addr=0 SHALL give ram_addr 0x1FFFFFF then 0x0000000.
